// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response collector slice.
//   - puf_state_e            : collector state (IDLE / COLLECT / DONE)
//   - PUF_RESP_BITS_DEFAULT  : default response width (16)
//   - PUF_SAMPLE_COUNT_DEFAULT: default sample count at which bits are captured (250)
//   - puf_clog2_min1()       : counter width helper that never returns 0
package puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } puf_state_e;

    localparam int PUF_RESP_BITS_DEFAULT    = 16;
    localparam int PUF_SAMPLE_COUNT_DEFAULT = 250;

    // Width needed to index 'value' distinct states, at least one bit.
    function automatic int puf_clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/puf_vote_accumulator.sv
// Per-bit ones-counter bank with majority threshold, used when the collector
// runs several passes and votes on each response bit.
// Ports:
//   clk       in   clock
//   Reset     in   synchronous active-high reset (counters to zero)
//   clear     in   synchronous clear at the start of a new collection
//   inc       in   RESP_BITS  per-bit increment strobes (a captured 1)
//   majority  out  RESP_BITS  1 where the bit was seen as 1 in more than half the passes
module puf_vote_accumulator
    import puf_pkg::*;
#(
    parameter int RESP_BITS = PUF_RESP_BITS_DEFAULT,
    parameter int NUM_VOTES = 3
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 clear,
    input  logic [RESP_BITS-1:0] inc,
    output logic [RESP_BITS-1:0] majority
);

    localparam int               CNT_W = puf_clog2_min1(NUM_VOTES + 1);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(NUM_VOTES / 2);

    logic [CNT_W-1:0] ones_r [RESP_BITS];

    // Ones counters; each can reach at most NUM_VOTES so no saturation is needed.
    always_ff @(posedge clk) begin
        if (Reset || clear) begin
            for (int i = 0; i < RESP_BITS; i++) begin
                ones_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RESP_BITS; i++) begin
                if (inc[i]) begin
                    ones_r[i] <= ones_r[i] + CNT_W'(1);
                end else begin
                    ones_r[i] <= ones_r[i];
                end
            end
        end
    end

    // Strict majority of an odd vote count.
    always_comb begin
        majority = '0;
        for (int i = 0; i < RESP_BITS; i++) begin
            majority[i] = (ones_r[i] > HALF);
        end
    end

endmodule

// File: rtl/puf_response_collector.sv
// PUF response collector: captures LANES RO-comparison bits per round when the
// controller's sample count reaches SAMPLE_COUNT, tracks filled rounds in a mask
// and presents the RESP_BITS word over a valid/ready handshake.
// Optional feature macro: PUF_RESP_MAJORITY_EN -- repeat NUM_VOTES passes and
// output the per-bit majority (uses puf_vote_accumulator).
// Ports:
//   clk, Reset        clock, synchronous active-high reset
//   start             begin a collection (accepted in IDLE only)
//   bit_in[LANES]     comparison bits; lane k -> resp_data[round*LANES+k]
//   round, count      current round / sample count from the round controller
//   busy              high while collecting
//   pass_done         one-cycle pulse when every round of a pass is captured
//   resp_valid/ready  response handshake
//   resp_data         collected response word
module puf_response_collector
    import puf_pkg::*;
#(
    parameter int RESP_BITS    = PUF_RESP_BITS_DEFAULT,
    parameter int LANES        = 1,
    parameter int ROUND_W      = 4,
    parameter int COUNT_W      = 8,
    parameter int SAMPLE_COUNT = PUF_SAMPLE_COUNT_DEFAULT,
    parameter int NUM_VOTES    = 3
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [LANES-1:0]     bit_in,
    input  logic [ROUND_W-1:0]   round,
    input  logic [COUNT_W-1:0]   count,
    output logic                 busy,
    output logic                 pass_done,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp_data
);

    // NUM_VOTES contributes nothing to the round count; it only matters with voting.
    localparam int                 ROUNDS     = (RESP_BITS / LANES) + (0 * NUM_VOTES);
    localparam int                 RLIM_W     = ROUND_W + 1;
    localparam logic [RLIM_W-1:0]  ROUNDS_LIM = RLIM_W'(ROUNDS);
    localparam logic [COUNT_W-1:0] SAMPLE_AT  = COUNT_W'(SAMPLE_COUNT);

    puf_state_e           state_r;
    puf_state_e           state_nxt_s;
    logic [RESP_BITS-1:0] resp_data_r;
    logic [RESP_BITS-1:0] data_nxt_s;
    logic [ROUNDS-1:0]    mask_r;
    logic [ROUNDS-1:0]    mask_nxt_s;
    logic [ROUNDS-1:0]    hit_s;
    logic [ROUNDS-1:0]    mask_merged_s;
    logic                 busy_r;
    logic                 pass_done_r;
    logic                 resp_valid_r;
    logic                 pass_done_nxt_s;
    logic                 valid_nxt_s;
    logic                 sample_s;
    logic                 cap_en_s;
    logic                 pass_full_s;

`ifdef PUF_RESP_MAJORITY_EN
    localparam int                PASS_W    = puf_clog2_min1(NUM_VOTES);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_VOTES - 1);

    logic [PASS_W-1:0]    pass_idx_r;
    logic [PASS_W-1:0]    pass_idx_nxt_s;
    logic                 finalize_r;
    logic                 finalize_nxt_s;
    logic                 vote_clear_s;
    logic [RESP_BITS-1:0] vote_inc_s;
    logic [RESP_BITS-1:0] vote_major_s;
`else
    logic [RESP_BITS-1:0] data_cap_s;
`endif

    // Capture qualifier: exact sample count, round within the response, collecting.
    always_comb begin
        sample_s = (count == SAMPLE_AT) && ({1'b0, round} < ROUNDS_LIM);
`ifdef PUF_RESP_MAJORITY_EN
        // The cycle spent loading the majority word takes no captures.
        cap_en_s = sample_s && (state_r == ST_COLLECT) && !finalize_r;
`else
        cap_en_s = sample_s && (state_r == ST_COLLECT);
`endif
    end

    // One-hot round decode and the mask as it will look after this capture.
    always_comb begin
        hit_s = '0;
        for (int r = 0; r < ROUNDS; r++) begin
            hit_s[r] = cap_en_s && (round == ROUND_W'(r));
        end
        mask_merged_s = mask_r | hit_s;
        pass_full_s   = cap_en_s && (&mask_merged_s);
    end

`ifdef PUF_RESP_MAJORITY_EN
    // Only the first capture of a round in a pass is counted.
    always_comb begin
        vote_inc_s = '0;
        for (int r = 0; r < ROUNDS; r++) begin
            for (int k = 0; k < LANES; k++) begin
                vote_inc_s[r*LANES + k] = hit_s[r] && !mask_r[r] && bit_in[k];
            end
        end
    end

    puf_vote_accumulator #(
        .RESP_BITS (RESP_BITS),
        .NUM_VOTES (NUM_VOTES)
    ) u_vote (
        .clk      (clk),
        .Reset    (Reset),
        .clear    (vote_clear_s),
        .inc      (vote_inc_s),
        .majority (vote_major_s)
    );
`else
    // Slice overwrite: a re-captured round simply replaces its bits.
    always_comb begin
        data_cap_s = resp_data_r;
        for (int r = 0; r < ROUNDS; r++) begin
            data_cap_s[r*LANES +: LANES] = hit_s[r] ? bit_in : resp_data_r[r*LANES +: LANES];
        end
    end
`endif

    // Next-state and next-output logic of the collector FSM.
    always_comb begin
        state_nxt_s     = state_r;
        data_nxt_s      = resp_data_r;
        mask_nxt_s      = mask_r;
        pass_done_nxt_s = 1'b0;
        valid_nxt_s     = resp_valid_r;
`ifdef PUF_RESP_MAJORITY_EN
        pass_idx_nxt_s  = pass_idx_r;
        finalize_nxt_s  = finalize_r;
        vote_clear_s    = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s    = ST_COLLECT;
                    data_nxt_s     = '0;
                    mask_nxt_s     = '0;
`ifdef PUF_RESP_MAJORITY_EN
                    pass_idx_nxt_s = '0;
                    finalize_nxt_s = 1'b0;
                    vote_clear_s   = 1'b1;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
`ifdef PUF_RESP_MAJORITY_EN
                if (finalize_r) begin
                    state_nxt_s    = ST_DONE;
                    valid_nxt_s    = 1'b1;
                    data_nxt_s     = vote_major_s;
                    finalize_nxt_s = 1'b0;
                end else if (pass_full_s) begin
                    pass_done_nxt_s = 1'b1;
                    mask_nxt_s      = '0;
                    if (pass_idx_r == PASS_LAST) begin
                        finalize_nxt_s = 1'b1;
                    end else begin
                        pass_idx_nxt_s = pass_idx_r + PASS_W'(1);
                    end
                end else if (cap_en_s) begin
                    mask_nxt_s = mask_merged_s;
                end else begin
                    mask_nxt_s = mask_r;
                end
`else
                if (cap_en_s) begin
                    data_nxt_s = data_cap_s;
                    mask_nxt_s = mask_merged_s;
                    if (pass_full_s) begin
                        pass_done_nxt_s = 1'b1;
                        state_nxt_s     = ST_DONE;
                        valid_nxt_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_COLLECT;
                    end
                end else begin
                    data_nxt_s = resp_data_r;
                end
`endif
            end
            ST_DONE: begin
                // Word and valid are frozen until accepted; start here is dropped.
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Collector state and registered outputs; Reset overrides everything.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            resp_data_r  <= '0;
            mask_r       <= '0;
            busy_r       <= 1'b0;
            pass_done_r  <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            resp_data_r  <= data_nxt_s;
            mask_r       <= mask_nxt_s;
            busy_r       <= (state_nxt_s == ST_COLLECT);
            pass_done_r  <= pass_done_nxt_s;
            resp_valid_r <= valid_nxt_s;
        end
    end

`ifdef PUF_RESP_MAJORITY_EN
    // Pass index and the one-cycle majority load flag.
    always_ff @(posedge clk) begin
        if (Reset) begin
            pass_idx_r <= '0;
            finalize_r <= 1'b0;
        end else begin
            pass_idx_r <= pass_idx_nxt_s;
            finalize_r <= finalize_nxt_s;
        end
    end
`endif

    assign busy       = busy_r;
    assign pass_done  = pass_done_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;

endmodule

// File: tb/tb_puf_response_collector.sv
`timescale 1ns/1ps
module tb_puf_response_collector;

    localparam int SC = 250;
    localparam int NV = 3;
`ifdef PUF_RESP_MAJORITY_EN
    localparam int PASSES = NV;
`else
    localparam int PASSES = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset, start, bit_in, resp_ready;
    logic [3:0]  round;
    logic [7:0]  count;
    logic        busy, pass_done, resp_valid;
    logic [15:0] resp_data;

    logic        start2, resp_ready2;
    logic [1:0]  bit_in2;
    logic [3:0]  round2;
    logic [7:0]  count2;
    logic        busy2, pass_done2, resp_valid2;
    logic [15:0] resp_data2;

    int checks;
    int errors;

    puf_response_collector #(
        .RESP_BITS(16), .LANES(1), .ROUND_W(4), .COUNT_W(8), .SAMPLE_COUNT(SC), .NUM_VOTES(NV)
    ) dut (
        .clk(clk), .Reset(Reset), .start(start), .bit_in(bit_in), .round(round), .count(count),
        .busy(busy), .pass_done(pass_done), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data)
    );

    puf_response_collector #(
        .RESP_BITS(16), .LANES(2), .ROUND_W(4), .COUNT_W(8), .SAMPLE_COUNT(SC), .NUM_VOTES(NV)
    ) dut2 (
        .clk(clk), .Reset(Reset), .start(start2), .bit_in(bit_in2), .round(round2), .count(count2),
        .busy(busy2), .pass_done(pass_done2), .resp_valid(resp_valid2), .resp_ready(resp_ready2),
        .resp_data(resp_data2)
    );

    // Reference model of the single-lane collector, expressed in terms of passes,
    // filled rounds and per-bit ones tallies.
    int          m_phase;      // 0 idle, 1 collecting, 2 word offered
    bit          m_wait;       // voting: majority word due next cycle
    logic [15:0] m_word;
    logic [15:0] m_filled;
    int          m_ones [16];
    int          m_pass;
    bit          m_pd;
    bit          m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic [3:0] rd,
                              input logic [7:0] cnt, input logic b, input logic rdy);
        m_pd = 1'b0;
        if (rst) begin
            m_phase = 0; m_wait = 1'b0; m_word = '0; m_filled = '0; m_pass = 0; m_valid = 1'b0;
            for (int i = 0; i < 16; i++) m_ones[i] = 0;
        end else if (m_phase == 0) begin
            if (st) begin
                m_phase = 1; m_wait = 1'b0; m_word = '0; m_filled = '0; m_pass = 0;
                for (int i = 0; i < 16; i++) m_ones[i] = 0;
            end
        end else if (m_phase == 1) begin
            if (m_wait) begin
                m_wait = 1'b0; m_phase = 2; m_valid = 1'b1;
                for (int i = 0; i < 16; i++) m_word[i] = (m_ones[i] * 2 > PASSES);
            end else if (int'(cnt) == SC) begin
                if (PASSES == 1) m_word[rd] = b;
                else if (!m_filled[rd]) m_ones[rd] += int'(b);
                m_filled[rd] = 1'b1;
                if (&m_filled) begin
                    m_pd = 1'b1; m_filled = '0; m_pass++;
                    if (m_pass == PASSES) begin
                        if (PASSES == 1) begin m_phase = 2; m_valid = 1'b1; end
                        else m_wait = 1'b1;
                    end
                end
            end
        end else begin
            if (rdy) begin m_phase = 0; m_valid = 1'b0; end
        end
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare at the next fall.
    task automatic cyc(input logic rst, input logic st, input logic [3:0] rd,
                       input logic [7:0] cnt, input logic b, input logic rdy);
        Reset = rst; start = st; round = rd; count = cnt; bit_in = b; resp_ready = rdy;
        @(posedge clk);
        model_edge(rst, st, rd, cnt, b, rdy);
        @(negedge clk);
        chk("busy", busy, m_phase == 1);
        chk("pass_done", pass_done, m_pd);
        chk("resp_valid", resp_valid, m_valid);
        chk("resp_data", resp_data, m_word);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        st;
        logic [3:0]  rd;
        logic [7:0]  cnt;
        logic        b;
        logic        rdy;
        logic        exp_valid;
        logic        exp_pd;
        logic        chk_data;
        logic [15:0] exp_data;
    } vec_t;

    vec_t        tbl [18];
    logic [15:0] held;
    logic [15:0] single_word;
    logic [2:0]  v0, v1;
    int          pd_cnt;

    initial begin
        checks = 0; errors = 0;
        start2 = 1'b0; resp_ready2 = 1'b0; bit_in2 = 2'b00; round2 = 4'd0; count2 = 8'd0;
        Reset = 1'b1; start = 1'b0; round = 4'd0; count = 8'd0; bit_in = 1'b0; resp_ready = 1'b0;
        m_phase = 0; m_wait = 1'b0; m_word = '0; m_filled = '0; m_pass = 0; m_pd = 1'b0; m_valid = 1'b0;
        for (int i = 0; i < 16; i++) m_ones[i] = 0;

        // Test 1 vectors: start, rounds 0..15 with bit = round[0], then handshake.
        single_word = (PASSES == 1) ? 16'hAAAA : 16'h0000;
        tbl[0] = '{1'b1, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
        for (int r = 0; r < 16; r++) begin
            tbl[r+1] = '{1'b0, 4'(r), 8'(SC), r[0], 1'b0, (r == 15) && (PASSES == 1),
                         r == 15, r == 15, single_word};
        end
        tbl[17] = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, single_word};

        @(negedge clk);
        cyc(1'b1, 1'b1, 4'd5, 8'(SC), 1'b1, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", resp_valid, 1'b0);
        chk("rst_data", resp_data, 16'h0000);
        chk("rst_busy2", busy2, 1'b0);
        chk("rst_valid2", resp_valid2, 1'b0);

        for (int i = 0; i < 18; i++) begin
            cyc(1'b0, tbl[i].st, tbl[i].rd, tbl[i].cnt, tbl[i].b, tbl[i].rdy);
            chk("tbl_valid", resp_valid, tbl[i].exp_valid);
            chk("tbl_pass_done", pass_done, tbl[i].exp_pd);
            if (tbl[i].chk_data) chk("tbl_data", resp_data, tbl[i].exp_data);
        end

        // Test 2: two lanes, 8 rounds of 2'b10, an out-of-range round 9 in between.
        cyc(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        start2 = 1'b1; idle(); start2 = 1'b0;
        chk("t2_busy", busy2, 1'b1);
        count2 = 8'(SC);
        for (int p = 0; p < PASSES; p++) begin
            for (int r = 0; r < 8; r++) begin
                round2 = 4'(r); bit_in2 = 2'b10; idle();
                if (!(p == PASSES - 1 && r == 7)) chk("t2_early_valid", resp_valid2, 1'b0);
                if (r == 3) begin
                    round2 = 4'd9; bit_in2 = 2'b01; idle();
                    chk("t2_round9_valid", resp_valid2, 1'b0);
                end
            end
        end
        chk("t2_valid_latency", resp_valid2, PASSES == 1);
        count2 = 8'd0;
        for (int w = 0; w < 4 && !resp_valid2; w++) idle();
        chk("t2_valid", resp_valid2, 1'b1);
        chk("t2_data", resp_data2, 16'hAAAA);
        resp_ready2 = 1'b1; idle(); resp_ready2 = 1'b0;
        chk("t2_handshake_valid", resp_valid2, 1'b0);
        chk("t2_handshake_busy", busy2, 1'b0);

        // Test 3: round 3 captured twice, off-by-one counts never capture.
        cyc(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd3, 8'(SC), 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 4'd3, 8'(SC), 1'b0, 1'b0);
        for (int r = 0; r < 15; r++) begin
            if (r != 3) cyc(1'b0, 1'b0, 4'(r), 8'(SC), 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 4'd15, 8'(SC - 1), 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 4'd15, 8'(SC + 1), 1'b1, 1'b0);
        end
        chk("t3_no_early_valid", resp_valid, 1'b0);
        cyc(1'b0, 1'b0, 4'd15, 8'(SC), 1'b1, 1'b0);
        chk("t3_data", resp_data, (PASSES == 1) ? 16'hFFF7 : 16'h0000);

        // Test 4: consumer stalls 20 cycles while inputs toggle.
        held = m_word;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, i[0], 4'($urandom_range(0, 15)), 8'(SC), 1'($urandom), 1'b0);
        end
        chk("t4_data_held", resp_data, held);
        chk("t4_valid_held", resp_valid, PASSES == 1);
        cyc(1'b0, 1'b1, 4'd0, 8'd0, 1'b0, 1'b1);

        // Test 5: reset at round 7, then a fresh full collection.
        cyc(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0);
        for (int r = 0; r < 7; r++) cyc(1'b0, 1'b0, 4'(r), 8'(SC), 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 4'd7, 8'(SC), 1'b1, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_pass_done", pass_done, 1'b0);
        chk("t5_valid", resp_valid, 1'b0);
        chk("t5_data", resp_data, 16'h0000);
        cyc(1'b0, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0);
        for (int p = 0; p < PASSES; p++) begin
            for (int r = 0; r < 16; r++) cyc(1'b0, 1'b0, 4'(r), 8'(SC), 1'($urandom), 1'b0);
        end
        for (int w = 0; w < 4 && !m_valid; w++) idle();
        chk("t5_fresh_valid", resp_valid, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);

        // Test 6: three passes, bit0 = 1,0,1 and bit1 = 0,0,1.
        v0 = 3'b101; v1 = 3'b100; pd_cnt = 0;
        cyc(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < 16; r++) begin
                cyc(1'b0, 1'b0, 4'(r), 8'(SC), (r == 0) ? v0[p] : (r == 1) ? v1[p] : 1'b0, 1'b0);
                if (pass_done) pd_cnt++;
            end
        end
        for (int w = 0; w < 4 && !resp_valid; w++) begin
            idle();
            if (pass_done) pd_cnt++;
        end
        chk("t6_pass_done_pulses", pd_cnt, PASSES);
        chk("t6_valid", resp_valid, 1'b1);
        chk("t6_data_low", resp_data[1:0], 2'b01);
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);

        // Randomised traffic against the model.
        cyc(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 7) == 0),
                4'($urandom_range(0, 15)),
                ($urandom_range(0, 1) == 0) ? 8'(SC) : 8'($urandom_range(SC - 2, SC + 2)),
                1'($urandom),
                ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
